// File: rtl/wb_arb_pkg.sv
// Shared types for the write-back port arbiter.
// Source select codes, x0 constant and the MDU result entry.
package wb_arb_pkg;

  localparam logic SRC_PIPE = 1'b0;
  localparam logic SRC_MDU  = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        kill;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// MDU result FIFO: storage, pointers, count, kill-by-rd and pend lookup.
// Ports: push/push_entry in, pop in, kill_en/kill_rd in, head/empty/full out,
// pend_rs1/pend_rs2 in, pend_hit out. Sync active-low rst.
module wb_result_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  input  logic      kill_en,
  input  logic [4:0] kill_rd,
  input  logic [4:0] pend_rs1,
  input  logic [4:0] pend_rs2,
  output wb_entry_t head,
  output logic      empty,
  output logic      full,
  output logic      pend_hit
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t      mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic [AW-1:0]  offs [DEPTH];
  logic [DEPTH-1:0] live;

  // An index is live when its distance from the read pointer is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      offs[i] = AW'(i) - rd_ptr;
      live[i] = {1'b0, offs[i]} < count;
    end
  end

  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && !mem[i].kill &&
          ((pend_rs1 != REG_ZERO && mem[i].rd == pend_rs1) ||
           (pend_rs2 != REG_ZERO && mem[i].rd == pend_rs2)))
        pend_hit = 1'b1;
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && live[i] && mem[i].rd == kill_rd)
          mem[i].kill <= 1'b1;
      end
      // Push targets a non-live slot, so it never collides with a kill.
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline write-back and MDU.
// Pipeline wins; MDU results drain from a FIFO into idle slots.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_reg_file,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        rf_src,
  output logic        stall_req,
  input  logic [4:0]  pend_rs1,
  input  logic [4:0]  pend_rs2,
  output logic        pend_hit
);

  wb_entry_t head;
  wb_entry_t push_entry;
  logic      empty;
  logic      full;
  logic      fifo_hit;
  logic      pipe_own;
  logic      mdu_wr;
  logic      pop;
  logic      push;
  logic [3:0] starve_cnt;

  assign pipe_own = wb_reg_file && (wb_rd != REG_ZERO);
  assign mdu_wr   = !empty && !head.kill && !pipe_own;
  // A killed head leaves regardless of who owns the slot.
  assign pop      = !empty && (head.kill || !pipe_own);
  assign push     = mdu_valid && !full;

  assign push_entry.rd   = mdu_rd;
  assign push_entry.data = mdu_data;
  assign push_entry.kill = (mdu_rd == REG_ZERO);

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (pipe_own),
    .kill_rd    (wb_rd),
    .pend_rs1   (pend_rs1),
    .pend_rs2   (pend_rs2),
    .head       (head),
    .empty      (empty),
    .full       (full),
    .pend_hit   (fifo_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != 4'hF) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    rf_we     = 1'b0;
    rf_rd     = '0;
    rf_wdata  = '0;
    rf_src    = SRC_PIPE;
    stall_req = 1'b0;
    pend_hit  = 1'b0;
    mdu_ready = 1'b0;
    if (rst) begin
      mdu_ready = !full;
      stall_req = (starve_cnt >= 4'(STARVE_LIMIT));
      pend_hit  = fifo_hit;
      unique case (1'b1)
        pipe_own: begin
          rf_we    = 1'b1;
          rf_rd    = wb_rd;
          rf_wdata = wb_data;
          rf_src   = SRC_PIPE;
        end
        mdu_wr: begin
          rf_we    = 1'b1;
          rf_rd    = head.rd;
          rf_wdata = head.data;
          rf_src   = SRC_MDU;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter.
// Inputs change 1ns after posedge; outputs sampled at negedge.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_reg_file;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        rf_src;
  logic        stall_req;
  logic [4:0]  pend_rs1;
  logic [4:0]  pend_rs2;
  logic        pend_hit;

  int tests = 0;
  int fails = 0;
  logic bad9 = 1'b0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_reg_file (wb_reg_file),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .mdu_valid   (mdu_valid),
    .mdu_rd      (mdu_rd),
    .mdu_data    (mdu_data),
    .mdu_ready   (mdu_ready),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_wdata    (rf_wdata),
    .rf_src      (rf_src),
    .stall_req   (stall_req),
    .pend_rs1    (pend_rs1),
    .pend_rs2    (pend_rs2),
    .pend_hit    (pend_hit)
  );

  always @(negedge clk)
    if (rf_we && rf_src && rf_rd == 5'd9) bad9 = 1'b1;

  task automatic idle();
    wb_reg_file = 0; wb_rd = 0; wb_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    pend_rs1 = 0; pend_rs2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [42:0] o;
    rst = 0;
    idle();
    tick(); tick();
    @(negedge clk);
    o = {rf_we, rf_rd, rf_wdata, rf_src, stall_req, pend_hit, mdu_ready};
    tests++;
    if (o !== '0) begin
      fails++;
      $display("FAIL reset_outs got %h want 0", o);
    end
    tick();
    rst = 1;
    tick();
    @(negedge clk);
    tests++;
    if ({rf_we, stall_req, pend_hit, mdu_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL post_reset got %b want 0001",
               {rf_we, stall_req, pend_hit, mdu_ready});
    end
  endtask

  task automatic test_pipeline();
    tick();
    wb_reg_file = 1; wb_rd = 5; wb_data = 32'hA5A5A5A5;
    @(negedge clk);
    tests++;
    if ({rf_we, rf_rd, rf_wdata, rf_src} !== {1'b1, 5'd5, 32'hA5A5A5A5, 1'b0}) begin
      fails++;
      $display("FAIL pipe_write got we=%b rd=%0d d=%h src=%b want 1/5/a5a5a5a5/0",
               rf_we, rf_rd, rf_wdata, rf_src);
    end
    wb_rd = 0;
    #1;
    tests++;
    if (rf_we !== 1'b0) begin
      fails++;
      $display("FAIL pipe_x0 got we=%b want 0", rf_we);
    end
    tick();
    idle();
  endtask

  task automatic test_mdu_drain();
    mdu_valid = 1; mdu_rd = 7; mdu_data = 32'h1234; pend_rs1 = 7;
    @(negedge clk);
    tests++;
    if ({rf_we, pend_hit, mdu_ready} !== 3'b001) begin
      fails++;
      $display("FAIL drain_pre got we/hit/rdy=%b want 001",
               {rf_we, pend_hit, mdu_ready});
    end
    tick();
    mdu_valid = 0;
    @(negedge clk);
    tests++;
    if ({rf_we, rf_rd, rf_wdata, rf_src, pend_hit} !==
        {1'b1, 5'd7, 32'h1234, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL drain_write got we=%b rd=%0d d=%h src=%b hit=%b want 1/7/1234/1/1",
               rf_we, rf_rd, rf_wdata, rf_src, pend_hit);
    end
    tick();
    @(negedge clk);
    tests++;
    if ({rf_we, pend_hit} !== 2'b00) begin
      fails++;
      $display("FAIL drain_empty got we/hit=%b want 00", {rf_we, pend_hit});
    end
    idle();
  endtask

  task automatic test_x0_push();
    mdu_valid = 1; mdu_rd = 0; mdu_data = 32'hDEAD;
    tick();
    mdu_valid = 0;
    @(negedge clk);
    tests++;
    if ({rf_we, mdu_ready} !== 2'b01) begin
      fails++;
      $display("FAIL x0_push got we/rdy=%b want 01", {rf_we, mdu_ready});
    end
    tick();
    idle();
  endtask

  task automatic test_full_starve();
    wb_reg_file = 1; wb_rd = 10; wb_data = 32'hCAFE;
    mdu_valid = 1; mdu_rd = 3; mdu_data = 32'h33;
    tick();
    mdu_rd = 4; mdu_data = 32'h44;
    @(negedge clk);
    tests++;
    if ({mdu_ready, stall_req} !== 2'b10) begin
      fails++;
      $display("FAIL full_one got rdy/stall=%b want 10", {mdu_ready, stall_req});
    end
    tick();
    mdu_valid = 0;
    @(negedge clk);
    tests++;
    if ({mdu_ready, rf_src, rf_rd} !== {1'b0, 1'b0, 5'd10}) begin
      fails++;
      $display("FAIL full_two got rdy=%b src=%b rd=%0d want 0/0/10",
               mdu_ready, rf_src, rf_rd);
    end
    tick(); tick();
    @(negedge clk);
    tests++;
    if (stall_req !== 1'b0) begin
      fails++;
      $display("FAIL starve_early got %b want 0", stall_req);
    end
    tick();
    @(negedge clk);
    tests++;
    if (stall_req !== 1'b1) begin
      fails++;
      $display("FAIL starve_hit got %b want 1", stall_req);
    end
    tick();
    wb_reg_file = 0;
    @(negedge clk);
    tests++;
    if ({rf_we, rf_rd, rf_wdata, rf_src, stall_req, mdu_ready} !==
        {1'b1, 5'd3, 32'h33, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL idle_slot got we=%b rd=%0d d=%h src=%b stall=%b rdy=%b want 1/3/33/1/1/0",
               rf_we, rf_rd, rf_wdata, rf_src, stall_req, mdu_ready);
    end
    tick();
    @(negedge clk);
    tests++;
    if ({stall_req, mdu_ready, rf_we, rf_rd} !== {1'b0, 1'b1, 1'b1, 5'd4}) begin
      fails++;
      $display("FAIL after_pop got stall=%b rdy=%b we=%b rd=%0d want 0/1/1/4",
               stall_req, mdu_ready, rf_we, rf_rd);
    end
    tick();
    idle();
  endtask

  task automatic test_waw_kill();
    bad9 = 1'b0;
    wb_reg_file = 1; wb_rd = 12; wb_data = 32'h1;
    mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99;
    tick();
    mdu_valid = 0;
    wb_rd = 9; wb_data = 32'h2; pend_rs1 = 9;
    @(negedge clk);
    tests++;
    if ({pend_hit, rf_src, rf_rd} !== {1'b1, 1'b0, 5'd9}) begin
      fails++;
      $display("FAIL waw_pre got hit=%b src=%b rd=%0d want 1/0/9",
               pend_hit, rf_src, rf_rd);
    end
    tick();
    wb_reg_file = 0; wb_rd = 0;
    @(negedge clk);
    tests++;
    if ({pend_hit, rf_we} !== 2'b00) begin
      fails++;
      $display("FAIL waw_killed got hit/we=%b want 00", {pend_hit, rf_we});
    end
    tick();
    @(negedge clk);
    tests++;
    if ({rf_we, bad9} !== 2'b00) begin
      fails++;
      $display("FAIL waw_silent got we=%b bad9=%b want 0/0", rf_we, bad9);
    end
    idle();
  endtask

  task automatic test_push_pop();
    mdu_valid = 1; mdu_rd = 20; mdu_data = 32'h20;
    tick();
    mdu_rd = 21; mdu_data = 32'h21;
    @(negedge clk);
    tests++;
    if ({rf_we, rf_rd, rf_src, mdu_ready} !== {1'b1, 5'd20, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL pp_old got we=%b rd=%0d src=%b rdy=%b want 1/20/1/1",
               rf_we, rf_rd, rf_src, mdu_ready);
    end
    tick();
    mdu_valid = 0;
    @(negedge clk);
    tests++;
    if ({rf_we, rf_rd, rf_wdata, mdu_ready} !== {1'b1, 5'd21, 32'h21, 1'b1}) begin
      fails++;
      $display("FAIL pp_new got we=%b rd=%0d d=%h rdy=%b want 1/21/21/1",
               rf_we, rf_rd, rf_wdata, mdu_ready);
    end
    tick();
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b0) begin
      fails++;
      $display("FAIL pp_empty got we=%b want 0", rf_we);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [42:0] o;
    wb_reg_file = 1; wb_rd = 10; wb_data = 32'h5;
    mdu_valid = 1; mdu_rd = 13; mdu_data = 32'h13;
    tick();
    mdu_rd = 14; mdu_data = 32'h14;
    tick();
    mdu_valid = 0; pend_rs1 = 13;
    rst = 0;
    @(negedge clk);
    o = {rf_we, rf_rd, rf_wdata, rf_src, stall_req, pend_hit, mdu_ready};
    tests++;
    if (o !== '0) begin
      fails++;
      $display("FAIL mid_reset_outs got %h want 0", o);
    end
    tick();
    rst = 1;
    wb_reg_file = 0; wb_rd = 0;
    @(negedge clk);
    tests++;
    if ({rf_we, pend_hit, mdu_ready} !== 3'b001) begin
      fails++;
      $display("FAIL mid_reset_after got we/hit/rdy=%b want 001",
               {rf_we, pend_hit, mdu_ready});
    end
    tick();
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_nowr got we=%b want 0", rf_we);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_mdu_drain();
    test_x0_push();
    test_full_starve();
    test_waw_kill();
    test_push_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline write-back stage and a long-latency multiply/divide unit (MDU) that returns results out of band. The pipeline write always wins. MDU results wait in a small FIFO and drain into idle write-back slots. A starvation counter requests a pipeline bubble when a result has waited too long, and a per-entry kill bit prevents stale MDU results from overwriting younger pipeline writes (WAW).

## Interface
- DEPTH, 2, MDU result FIFO entries; power of two, ≥2
- STARVE_LIMIT, 4, cycles a non-empty FIFO head may wait before `stall_req` asserts; 1–15
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low
- wb_reg_file  in  1  pipeline write-back requests a register write
- wb_rd  in  5  pipeline destination register
- wb_data  in  32  pipeline write data (load data or calculated result, already selected)
- mdu_valid  in  1  MDU offers a result
- mdu_rd  in  5  MDU destination register
- mdu_data  in  32  MDU result
- mdu_ready  out  1  FIFO can accept; equals !full
- rf_we  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- rf_src  out  1  0 = pipeline, 1 = MDU
- stall_req  out  1  request to the hazard unit to insert one write-back bubble
- pend_rs1, pend_rs2  in  5 each  decode-stage source registers
- pend_hit  out  1  a live, unkilled FIFO entry targets a nonzero `pend_rs1`/`pend_rs2`

## Operation
- **Pipeline slot:** the pipeline owns the slot when `wb_reg_file=1` and `wb_rd!=0`. In that case `rf_we=1`, `rf_rd=wb_rd`, `rf_wdata=wb_data`, `rf_src=0`. The path is combinational, with zero added latency.
- **Free slot:** otherwise, if the FIFO head is live and unkilled, the head drives the port with `rf_src=1` and is popped at the edge.
- **Killed head:** a killed head is popped in any cycle without a write, whether or not the pipeline owns the slot.
- **x0 writes:** writes to x0 never assert `rf_we`. An MDU result with `mdu_rd=0` is accepted and stored already killed.
- **Push:** occurs on `mdu_valid & mdu_ready`. The entry becomes visible as head no earlier than the next cycle.
- **Kill:** when the pipeline owns the slot, every stored entry with `rd==wb_rd` gets its kill bit set at that edge. The entry being pushed in the same cycle is not killed; the issue logic guarantees its ordering.
- **Starvation counter:** 4-bit. Clears when the FIFO is empty or a pop occurs. Otherwise it increments and saturates at 15. `stall_req = (cnt >= STARVE_LIMIT)`.
- **`pend_hit`:** combinational over live, unkilled entries, including the head.

## Timing
- **Reset (`rst=0` at edge):** FIFO pointers, count, kill bits and counter all clear.
- **Outputs during reset:** while `rst=0`, all outputs are forced to 0: `rf_we`, `rf_rd`, `rf_wdata`, `rf_src`, `stall_req`, `pend_hit`, and `mdu_ready`. Reset mid-operation discards buffered results.
- **Latency:** pipeline path 0 cycles. MDU path at least 1 cycle from accept to write.
- **Full FIFO:** `mdu_ready=0` even if a pop occurs in the same cycle; no bypass. The MDU holds `mdu_valid`/`mdu_rd`/`mdu_data` stable until accepted.
- **Push and pop same cycle:** when not full, both occur and the count is unchanged.
- **Pointer wrap:** pointers wrap modulo DEPTH. Full/empty is determined from the count register (width `clog2(DEPTH)+1`).
- **Stall handshake:** `stall_req` stays high until the first pop. The hazard unit's bubble arrives as `wb_reg_file=0` some cycles later. The arbiter does not track bubbles.

## Structure
- **Shared package `wb_arb_pkg`:**
  - `SRC_PIPE=1'b0`, `SRC_MDU=1'b1`
  - `REG_ZERO=5'd0`
  - entry struct: rd, data, kill
- **Sub-module `wb_result_fifo`:** the natural split. It holds storage, pointers, count, kill-by-rd compare and pend lookup. The arbiter top holds port select, pop decision and the starvation counter.

## Test plan
- **Pipeline only:** `wb_reg_file=1`, `wb_rd=5`, `wb_data=0xA5A5A5A5` → same cycle `rf_we=1`, `rf_rd=5`, `rf_src=0`. With `wb_rd=0` → `rf_we=0`.
- **MDU drain:** accept `rd=7`, `data=0x1234`, with the pipeline idle → next cycle `rf_we=1`, `rf_rd=7`, `rf_src=1`; FIFO then empty.
- **Full and starvation:** pipeline writes every cycle. Push rd 3, then rd 4 → `mdu_ready=0` after the second push. `stall_req=1` 4 cycles after the first entry became head. One idle slot → rd 3 written, `stall_req=0`, `mdu_ready=1`.
- **WAW kill:** buffer rd 9, then pipeline writes rd 9 → the entry is popped silently on the next cycle. `rf_we` is never asserted with `rf_src=1` and `rf_rd=9`. `pend_hit` for `rs1=9` drops to 0 after the kill edge.
- **Simultaneous push and pop:** FIFO holding 1 entry, pipeline idle, `mdu_valid=1` → write of the old head and push of the new entry in the same cycle; count stays 1.
- **Reset mid-operation:** 2 entries buffered, `rst=0` for 1 cycle → all outputs 0 during reset. Afterwards FIFO empty, no MDU write occurs, `mdu_ready=1`.
